// File: rtl/eth_min_frame_padder.sv
// Purpose: pads Ethernet frames (no FCS) shorter than MIN_BYTES with zero bytes.
// Latency: one registered output stage, 1 cycle in -> out.
// Backpressure: sink ready = output slot free and not emitting pad beats; output held while stalled.
// Ports: clk/rst (async, active-high); snk_* Avalon-ST sink (data/valid/sop/eop/empty, ready out);
//        src_* Avalon-ST source (data/valid/sop/eop/empty, ready in); sync_err 1-cycle framing-error pulse;
//        padded_cnt (only with PADDER_STATS_EN defined) counts frames that needed pad beats.
// Byte 0 of a beat is data[31:24]; empty counts unused bytes at the low end of the last beat.
module eth_min_frame_padder #(
  parameter int DATA_WIDTH = 32,
  parameter int MIN_BYTES  = 60
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] snk_data,
  input  logic                  snk_valid,
  input  logic                  snk_sop,
  input  logic                  snk_eop,
  input  logic [1:0]            snk_empty,
  output logic                  snk_ready,
  output logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_valid,
  output logic                  src_sop,
  output logic                  src_eop,
  output logic [1:0]            src_empty,
  input  logic                  src_ready,
  output logic                  sync_err
`ifdef PADDER_STATS_EN
  ,
  output logic [15:0]           padded_cnt
`endif
);

  localparam int CW = $clog2(MIN_BYTES) + 1;
  // One extra bit so byte_cnt + 4 never wraps.
  localparam int SW = CW + 1;
  localparam logic [SW-1:0] MIN_W = SW'(MIN_BYTES);
  localparam logic [CW-1:0] MIN_C = CW'(MIN_BYTES);
  localparam logic [1:0] PAD_EMPTY = 2'((4 - MIN_BYTES % 4) % 4);

  typedef enum logic [1:0] {IDLE, PKT, PAD} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         byte_cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic                  valid_nxt, sop_nxt, eop_nxt, err_nxt;
  logic [1:0]            empty_nxt;
  logic                  load, acc;
  logic [2:0]            beat_bytes;
  logic [SW-1:0]         base, total, rounded, pad_next;
  logic [DATA_WIDTH-1:0] keep_mask;
`ifdef PADDER_STATS_EN
  logic                  stat_inc;
`endif

  assign load      = !src_valid || src_ready;
  // Gated by rst so ready reads 0 while reset is held.
  assign snk_ready = !rst && load && (state != PAD);
  assign acc       = snk_valid && snk_ready;

  // A sop beat always restarts the count, even if it arrives mid-frame.
  assign base       = snk_sop ? '0 : SW'(byte_cnt);
  assign beat_bytes = snk_eop ? (3'd4 - {1'b0, snk_empty}) : 3'd4;
  assign total      = base + SW'(beat_bytes);
  assign rounded    = base + SW'(3'd4);
  assign pad_next   = SW'(byte_cnt) + SW'(3'd4);
  assign keep_mask  = {DATA_WIDTH{1'b1}} << {snk_empty, 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      src_data  <= '0;
      src_valid <= 1'b0;
      src_sop   <= 1'b0;
      src_eop   <= 1'b0;
      src_empty <= 2'd0;
      sync_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      byte_cnt  <= cnt_nxt;
      src_data  <= data_nxt;
      src_valid <= valid_nxt;
      src_sop   <= sop_nxt;
      src_eop   <= eop_nxt;
      src_empty <= empty_nxt;
      sync_err  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = byte_cnt;
    data_nxt  = src_data;
    valid_nxt = src_valid;
    sop_nxt   = src_sop;
    eop_nxt   = src_eop;
    empty_nxt = src_empty;
    err_nxt   = 1'b0;
`ifdef PADDER_STATS_EN
    stat_inc  = 1'b0;
`endif
    // A free slot with nothing new to put in it becomes a bubble.
    if (load) valid_nxt = 1'b0;

    case (state)
      PAD: begin
        if (load) begin
          valid_nxt = 1'b1;
          data_nxt  = '0;
          sop_nxt   = 1'b0;
          if (pad_next >= MIN_W) begin
            eop_nxt   = 1'b1;
            empty_nxt = PAD_EMPTY;
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            eop_nxt   = 1'b0;
            empty_nxt = 2'd0;
            cnt_nxt   = CW'(pad_next);
          end
        end
      end
      IDLE, PKT: begin
        if (acc) begin
          // sop inside a frame: the old frame is abandoned unterminated.
          if (snk_sop && state == PKT) err_nxt = 1'b1;
          if (!snk_sop && state == IDLE) begin
            // Orphan beat outside any frame: swallowed.
            err_nxt = 1'b1;
          end else begin
            valid_nxt = 1'b1;
            data_nxt  = snk_data;
            sop_nxt   = snk_sop;
            eop_nxt   = snk_eop;
            empty_nxt = snk_empty;
            if (!snk_eop) begin
              state_nxt = PKT;
              cnt_nxt   = (total >= MIN_W) ? MIN_C : CW'(total);
            end else if (total >= MIN_W) begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end else begin
              // Short frame: the tail bytes become the first pad bytes.
              data_nxt  = snk_data & keep_mask;
              empty_nxt = 2'd0;
              if (rounded >= MIN_W) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
              end else begin
                eop_nxt   = 1'b0;
                state_nxt = PAD;
                cnt_nxt   = CW'(rounded);
`ifdef PADDER_STATS_EN
                stat_inc  = 1'b1;
`endif
              end
            end
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef PADDER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) padded_cnt <= 16'd0;
    else if (stat_inc && padded_cnt != 16'hFFFF) padded_cnt <= padded_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_eth_min_frame_padder.sv
// Directed bench for eth_min_frame_padder: two instances (MIN_BYTES 60 and 62),
// a table of frames with hand-computed output lengths, plus multi-cycle corner sequences.
module tb_eth_min_frame_padder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [31:0] snk_data  [2];
  logic        snk_valid [2];
  logic        snk_sop   [2];
  logic        snk_eop   [2];
  logic [1:0]  snk_empty [2];
  logic        snk_ready [2];
  logic [31:0] src_data  [2];
  logic        src_valid [2];
  logic        src_sop   [2];
  logic        src_eop   [2];
  logic [1:0]  src_empty [2];
  logic        src_ready [2];
  logic        sync_err  [2];
`ifdef PADDER_STATS_EN
  logic [15:0] padded_cnt [2];
`endif

  eth_min_frame_padder #(.DATA_WIDTH(32), .MIN_BYTES(60)) dut60 (
    .clk(clk), .rst(rst),
    .snk_data(snk_data[0]), .snk_valid(snk_valid[0]), .snk_sop(snk_sop[0]),
    .snk_eop(snk_eop[0]), .snk_empty(snk_empty[0]), .snk_ready(snk_ready[0]),
    .src_data(src_data[0]), .src_valid(src_valid[0]), .src_sop(src_sop[0]),
    .src_eop(src_eop[0]), .src_empty(src_empty[0]), .src_ready(src_ready[0]),
    .sync_err(sync_err[0])
`ifdef PADDER_STATS_EN
    , .padded_cnt(padded_cnt[0])
`endif
  );

  eth_min_frame_padder #(.DATA_WIDTH(32), .MIN_BYTES(62)) dut62 (
    .clk(clk), .rst(rst),
    .snk_data(snk_data[1]), .snk_valid(snk_valid[1]), .snk_sop(snk_sop[1]),
    .snk_eop(snk_eop[1]), .snk_empty(snk_empty[1]), .snk_ready(snk_ready[1]),
    .src_data(src_data[1]), .src_valid(src_valid[1]), .src_sop(src_sop[1]),
    .src_eop(src_eop[1]), .src_empty(src_empty[1]), .src_ready(src_ready[1]),
    .sync_err(sync_err[1])
`ifdef PADDER_STATS_EN
    , .padded_cnt(padded_cnt[1])
`endif
  );

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
  } beat_t;

  typedef struct {
    int         sel;        // 0: MIN_BYTES=60, 1: MIN_BYTES=62
    int         nbytes;     // input frame length
    int         rmode;      // 0: src_ready=1, 1: src_ready toggles 1010
    int         exp_beats;  // expected output beats
    logic [1:0] exp_empty;  // expected empty on the last output beat
  } vec_t;

  int total_n = 0;
  int bad_n   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int k);
    return 8'(k + 17);
  endfunction

  // Drive beat bi of an nbytes frame if bi < lim, else idle. Unused lanes carry 0xEE.
  task automatic drive_beat(input int sel, input int bi, input int lim, input int nbytes);
    int nbeats;
    logic [31:0] d;
    nbeats = (nbytes + 3) / 4;
    if (bi < lim) begin
      for (int j = 0; j < 4; j++) begin
        int k;
        k = 4 * bi + j;
        d[31 - 8*j -: 8] = (k < nbytes) ? pat(k) : 8'hEE;
      end
      snk_valid[sel] = 1'b1;
      snk_sop[sel]   = (bi == 0);
      snk_eop[sel]   = (bi == nbeats - 1);
      snk_empty[sel] = (bi == nbeats - 1) ? 2'(4 * nbeats - nbytes) : 2'd0;
      snk_data[sel]  = d;
    end else begin
      snk_valid[sel] = 1'b0;
      snk_sop[sel]   = 1'b0;
      snk_eop[sel]   = 1'b0;
      snk_empty[sel] = 2'd0;
      snk_data[sel]  = 32'd0;
    end
  endtask

  // Push the first lim beats of a frame with the output always drained; no output checks.
  task automatic send_beats(input int sel, input int nbytes, input int lim);
    int bi;
    int cyc;
    logic acc;
    bi = 0;
    cyc = 0;
    src_ready[sel] = 1'b1;
    drive_beat(sel, bi, lim, nbytes);
    while (bi < lim && cyc < 100) begin
      @(negedge clk);
      acc = snk_valid[sel] && snk_ready[sel];
      @(posedge clk); #1;
      if (acc) bi++;
      cyc++;
      drive_beat(sel, bi, lim, nbytes);
    end
    check("send_beats accepted", bi, lim);
  endtask

  // Send one whole frame and collect the output frame, then compare against the byte model.
  task automatic run_frame(input int sel, input int nbytes, input int rmode, input int exp_beats,
                           input logic [1:0] exp_empty, input logic exp_sync, input string nm);
    int nbeats, bi, cyc, outlen, badflag, badb;
    logic got_eop, sync_seen, hold_pend, acc, rdy_s;
    beat_t held, cur;
    beat_t q[$];
    logic [7:0] expb;
    nbeats = (nbytes + 3) / 4;
    bi = 0;
    cyc = 0;
    got_eop = 1'b0;
    sync_seen = 1'b0;
    hold_pend = 1'b0;
    held = '0;
    src_ready[sel] = 1'b1;
    drive_beat(sel, bi, nbeats, nbytes);
    while (!got_eop && cyc < 400) begin
      @(negedge clk);
      rdy_s = snk_ready[sel];
      acc = snk_valid[sel] && rdy_s;
      cur = {src_data[sel], src_sop[sel], src_eop[sel], src_empty[sel]};
      if (sync_err[sel]) sync_seen = 1'b1;
      if (hold_pend) begin
        check($sformatf("%s hold data", nm), cur.data, held.data);
        check($sformatf("%s hold ctl", nm), {src_valid[sel], cur.sop, cur.eop, cur.empty},
              {1'b1, held.sop, held.eop, held.empty});
      end
      // Once the whole input frame is in, sink must stay closed until the final eop beat is loaded.
      if (bi >= nbeats && !(src_valid[sel] && src_eop[sel]))
        check($sformatf("%s ready during pad", nm), rdy_s, 1'b0);
      hold_pend = src_valid[sel] && !src_ready[sel];
      held = cur;
      if (src_valid[sel] && src_ready[sel]) begin
        q.push_back(cur);
        if (cur.eop) got_eop = 1'b1;
      end
      @(posedge clk); #1;
      if (acc) bi++;
      cyc++;
      drive_beat(sel, bi, nbeats, nbytes);
      src_ready[sel] = (rmode == 1) ? ((cyc % 2) == 0) : 1'b1;
    end
    src_ready[sel] = 1'b1;
    check($sformatf("%s eop seen", nm), got_eop, 1'b1);
    check($sformatf("%s beats", nm), q.size(), exp_beats);
    badflag = 0;
    foreach (q[i])
      if (q[i].sop !== (i == 0) || q[i].eop !== (i == q.size() - 1)) badflag++;
    check($sformatf("%s framing", nm), badflag, 0);
    outlen = exp_beats * 4 - int'(exp_empty);
    badb = 0;
    foreach (q[i]) begin
      for (int j = 0; j < 4; j++) begin
        int k;
        k = 4 * i + j;
        expb = (k < nbytes) ? pat(k) : 8'h00;
        if (k < outlen && q[i].data[31 - 8*j -: 8] !== expb) badb++;
      end
    end
    check($sformatf("%s bad bytes", nm), badb, 0);
    if (q.size() > 0) check($sformatf("%s last empty", nm), q[q.size()-1].empty, exp_empty);
    check($sformatf("%s sync_err", nm), sync_seen, exp_sync);
  endtask

  vec_t vecs[13];

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      snk_valid[s] = 1'b0; snk_sop[s] = 1'b0; snk_eop[s] = 1'b0;
      snk_empty[s] = 2'd0; snk_data[s] = 32'd0; src_ready[s] = 1'b1;
    end

    vecs[0]  = '{0, 16, 0, 15, 2'd0};
    vecs[1]  = '{0, 64, 0, 16, 2'd0};
    vecs[2]  = '{0, 13, 0, 15, 2'd0};
    vecs[3]  = '{0, 60, 0, 15, 2'd0};
    vecs[4]  = '{0, 59, 0, 15, 2'd0};
    vecs[5]  = '{0, 61, 0, 16, 2'd3};
    vecs[6]  = '{0,  1, 0, 15, 2'd0};
    vecs[7]  = '{0, 56, 0, 15, 2'd0};
    vecs[8]  = '{0, 16, 1, 15, 2'd0};
    vecs[9]  = '{1,  8, 0, 16, 2'd2};
    vecs[10] = '{1, 62, 0, 16, 2'd2};
    vecs[11] = '{1, 58, 1, 16, 2'd2};
    vecs[12] = '{0, 64, 1, 16, 2'd0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("reset src_valid[%0d]", s), src_valid[s], 1'b0);
      check($sformatf("reset src_sop_eop[%0d]", s), {src_sop[s], src_eop[s]}, 2'b00);
      check($sformatf("reset src_data[%0d]", s), src_data[s], 32'd0);
      check($sformatf("reset src_empty[%0d]", s), src_empty[s], 2'd0);
      check($sformatf("reset snk_ready[%0d]", s), snk_ready[s], 1'b0);
      check($sformatf("reset sync_err[%0d]", s), sync_err[s], 1'b0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 13; i++)
      run_frame(vecs[i].sel, vecs[i].nbytes, vecs[i].rmode, vecs[i].exp_beats,
                vecs[i].exp_empty, 1'b0, $sformatf("vec%0d", i));

    // Orphan beat in IDLE: accepted, not forwarded, one-cycle sync_err.
    snk_valid[0] = 1'b1; snk_sop[0] = 1'b0; snk_eop[0] = 1'b0; snk_data[0] = 32'hDEADBEEF;
    @(negedge clk);
    check("orphan accepted", snk_ready[0], 1'b1);
    @(posedge clk); #1;
    drive_beat(0, 0, 0, 4);
    @(negedge clk);
    check("orphan sync_err", sync_err[0], 1'b1);
    check("orphan dropped", src_valid[0], 1'b0);
    @(negedge clk);
    check("orphan sync_err pulse", sync_err[0], 1'b0);
    @(posedge clk); #1;

    // sop mid-frame: two beats of a 16-byte frame, then a fresh 16-byte frame.
    send_beats(0, 16, 2);
    repeat (2) begin @(posedge clk); #1; end
    run_frame(0, 16, 0, 15, 2'd0, 1'b1, "sop_mid");
    run_frame(0, 13, 0, 15, 2'd0, 1'b0, "after_sop_mid");

    // Reset in the middle of padding.
    send_beats(0, 16, 4);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("rst mid-pad src_valid", src_valid[0], 1'b0);
    @(negedge clk);
    check("rst mid-pad snk_ready", snk_ready[0], 1'b0);
    check("rst mid-pad src_valid hold", src_valid[0], 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_frame(0, 16, 0, 15, 2'd0, 1'b0, "after_rst");
    run_frame(1, 8, 0, 16, 2'd2, 1'b0, "after_rst62");

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
